// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one downstream memory port between the
// instruction port (A, read-only) and the data port (B, read/write).
//
// Ports:
//   clk, rst_n          clock, async active-low reset
//   read_a, address_a   instruction read request (held until resp_a)
//   resp_a, rdata_a     one-cycle completion pulse and read data for A
//   read_b, write_b     data read/write request (held until resp_b)
//   wmask_b, address_b  byte mask and address for B
//   wdata_b             write data for B
//   resp_b, rdata_b     one-cycle completion pulse and read data for B
//   mem_read/mem_write  downstream command, held until mem_resp
//   mem_wmask           downstream byte mask
//   mem_address         downstream address
//   mem_wdata           downstream write data
//   mem_resp, mem_rdata downstream completion and read data
//   err_timeout         sticky watchdog flag
//
// Optional feature macro: ARB_ROUND_ROBIN_EN
//   defined   -> a simultaneous A/B request goes to the port that was
//                not granted last
//   undefined -> B always wins over A
module mem_port_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  read_a,
    input  logic [ADDR_W-1:0]     address_a,
    output logic                  resp_a,
    output logic [DATA_W-1:0]     rdata_a,
    input  logic                  read_b,
    input  logic                  write_b,
    input  logic [DATA_W/8-1:0]   wmask_b,
    input  logic [ADDR_W-1:0]     address_b,
    input  logic [DATA_W-1:0]     wdata_b,
    output logic                  resp_b,
    output logic [DATA_W-1:0]     rdata_b,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic [DATA_W/8-1:0]   mem_wmask,
    output logic [ADDR_W-1:0]     mem_address,
    output logic [DATA_W-1:0]     mem_wdata,
    input  logic                  mem_resp,
    input  logic [DATA_W-1:0]     mem_rdata,
    output logic                  err_timeout
);

    localparam int MASK_W = DATA_W / 8;
    localparam int CNT_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

    typedef enum logic [2:0] {
        IDLE,
        GRANT_A,
        GRANT_B,
        DONE_A,
        DONE_B
    } state_t;

    state_t state;
    state_t state_nx;

    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_nx;
    logic [CNT_W-1:0]  cnt_inc;
    logic              last_b;
    logic              last_b_nx;

    logic              resp_a_nx;
    logic              resp_b_nx;
    logic [DATA_W-1:0] rdata_a_nx;
    logic [DATA_W-1:0] rdata_b_nx;
    logic              mem_read_nx;
    logic              mem_write_nx;
    logic [MASK_W-1:0] mem_wmask_nx;
    logic [ADDR_W-1:0] mem_address_nx;
    logic [DATA_W-1:0] mem_wdata_nx;
    logic              err_nx;

    logic              req_b;
    logic              pick_b;

    assign req_b = read_b | write_b;

`ifdef ARB_ROUND_ROBIN_EN
    // On a conflict, B only wins if A was served last.
    assign pick_b = req_b & (~read_a | ~last_b);
`else
    assign pick_b = req_b;
`endif

    // Saturating wait counter.
    assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + CNT_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            last_b      <= 1'b0;
            resp_a      <= 1'b0;
            resp_b      <= 1'b0;
            rdata_a     <= '0;
            rdata_b     <= '0;
            mem_read    <= 1'b0;
            mem_write   <= 1'b0;
            mem_wmask   <= '0;
            mem_address <= '0;
            mem_wdata   <= '0;
            err_timeout <= 1'b0;
        end else begin
            state       <= state_nx;
            cnt         <= cnt_nx;
            last_b      <= last_b_nx;
            resp_a      <= resp_a_nx;
            resp_b      <= resp_b_nx;
            rdata_a     <= rdata_a_nx;
            rdata_b     <= rdata_b_nx;
            mem_read    <= mem_read_nx;
            mem_write   <= mem_write_nx;
            mem_wmask   <= mem_wmask_nx;
            mem_address <= mem_address_nx;
            mem_wdata   <= mem_wdata_nx;
            err_timeout <= err_nx;
        end
    end

    always_comb begin
        state_nx       = state;
        cnt_nx         = cnt;
        last_b_nx      = last_b;
        resp_a_nx      = 1'b0;
        resp_b_nx      = 1'b0;
        rdata_a_nx     = rdata_a;
        rdata_b_nx     = rdata_b;
        mem_read_nx    = mem_read;
        mem_write_nx   = mem_write;
        mem_wmask_nx   = mem_wmask;
        mem_address_nx = mem_address;
        mem_wdata_nx   = mem_wdata;
        err_nx         = err_timeout;

        unique case (state)
            IDLE: begin
                if (pick_b) begin
                    state_nx       = GRANT_B;
                    cnt_nx         = '0;
                    mem_address_nx = address_b;
                    mem_wdata_nx   = wdata_b;
                    mem_wmask_nx   = wmask_b;
                    // write wins if both are (illegally) high
                    mem_write_nx   = write_b;
                    mem_read_nx    = ~write_b;
                end else if (read_a) begin
                    state_nx       = GRANT_A;
                    cnt_nx         = '0;
                    mem_address_nx = address_a;
                    mem_wdata_nx   = '0;
                    mem_wmask_nx   = '0;
                    mem_write_nx   = 1'b0;
                    mem_read_nx    = 1'b1;
                end
            end

            GRANT_A, GRANT_B: begin
                if (mem_resp) begin
                    cnt_nx       = '0;
                    mem_read_nx  = 1'b0;
                    mem_write_nx = 1'b0;
                    if (state == GRANT_A) begin
                        state_nx   = DONE_A;
                        resp_a_nx  = 1'b1;
                        rdata_a_nx = mem_rdata;
                        last_b_nx  = 1'b0;
                    end else begin
                        state_nx   = DONE_B;
                        resp_b_nx  = 1'b1;
                        rdata_b_nx = mem_rdata;
                        last_b_nx  = 1'b1;
                    end
                end else begin
                    cnt_nx = cnt_inc;
                    // flag once TIMEOUT grant cycles passed without a response
                    if ((TIMEOUT != 0) && (cnt_inc == CNT_MAX)) begin
                        err_nx = 1'b1;
                    end
                end
            end

            DONE_A, DONE_B: begin
                // requests are ignored here so a held request is not re-granted
                state_nx = IDLE;
            end

            default: begin
                state_nx = IDLE;
            end
        endcase
    end

endmodule
